// File: rtl/multi_drop_bus_tx.sv
// Multi-drop bus driver: FIFO-buffered (dest,data) commands become one-cycle EN/Bus slots separated by GAP_CYCLES idle cycles.
// Slot appears one edge after the command reaches an idle FSM; tx_ready = !full. Optional MDB_BROADCAST_EN expands dest=00 to three slots.
module multi_drop_bus_tx #(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic                        CLK,
  input  logic                        R,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  input  logic [1:0]                  tx_dest,
  input  logic [7:0]                  tx_data,
  output logic [7:0]                  Bus,
  output logic [1:0]                  EN,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        err
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_GAP} state_t;

  state_t        r_state;
  logic [9:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [2:0]    r_gap_cnt;
  logic [7:0]    r_bus;
  logic [1:0]    r_en;
  logic          r_err;

  logic       w_accept;
  logic       w_push;
  logic       w_pop;
  logic       w_start;
  logic       w_reject;
  logic       w_slot_pop;
  logic [1:0] w_slot_en;
  logic [1:0] w_head_dest;
  logic [7:0] w_head_data;

  assign tx_ready    = (r_level != (AW+1)'(FIFO_DEPTH));
  assign w_accept    = tx_valid && tx_ready;
  assign w_head_dest = r_mem[r_rd_ptr][9:8];
  assign w_head_data = r_mem[r_rd_ptr][7:0];

`ifdef MDB_BROADCAST_EN
  logic       w_head_bc;
  logic [1:0] r_bc_en;

  assign w_push     = w_accept;
  assign w_reject   = 1'b0;
  assign w_head_bc  = (w_head_dest == 2'b00);
  assign w_slot_en  = w_head_bc ? r_bc_en : w_head_dest;
  // A broadcast entry stays at the head until its final (EN=11) slot.
  assign w_slot_pop = !w_head_bc || (r_bc_en == 2'b11);

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_bc_en <= 2'b01;
    end else if (w_start && w_head_bc) begin
      r_bc_en <= w_slot_pop ? 2'b01 : r_bc_en + 2'b01;
    end
  end
`else
  assign w_push     = w_accept && (tx_dest != 2'b00);
  assign w_reject   = w_accept && (tx_dest == 2'b00);
  assign w_slot_en  = w_head_dest;
  assign w_slot_pop = 1'b1;
`endif

  always_comb begin
    w_start = 1'b0;
    if (r_level != '0) begin
      case (r_state)
        S_IDLE:  w_start = 1'b1;
        S_DRIVE: w_start = (GAP_CYCLES == 0);
        S_GAP:   w_start = (r_gap_cnt == 3'd0);
        default: w_start = 1'b0;
      endcase
    end
  end

  assign w_pop = w_start && w_slot_pop;

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {tx_dest, tx_data};
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      r_state   <= S_IDLE;
      r_bus     <= 8'h00;
      r_en      <= 2'b00;
      r_gap_cnt <= 3'd0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_reject;
      if (w_start) begin
        r_state <= S_DRIVE;
        r_bus   <= w_head_data;
        r_en    <= w_slot_en;
      end else begin
        case (r_state)
          S_DRIVE: begin
            r_en <= 2'b00;
            if (GAP_CYCLES > 0) begin
              r_state   <= S_GAP;
              // Counter reaching zero marks the last idle cycle of the gap.
              r_gap_cnt <= 3'(GAP_CYCLES - 1);
            end else begin
              r_state <= S_IDLE;
            end
          end
          S_GAP: begin
            if (r_gap_cnt == 3'd0) r_state <= S_IDLE;
            else                   r_gap_cnt <= r_gap_cnt - 3'd1;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign Bus   = r_bus;
  assign EN    = r_en;
  assign err   = r_err;
  assign level = r_level;
  assign busy  = (r_state != S_IDLE) || (r_level != '0);
endmodule

// File: tb/tb_multi_drop_bus_tx.sv
// Scoreboard bench for multi_drop_bus_tx: dut uses GAP_CYCLES=1, dut0 uses GAP_CYCLES=0.
module tb_multi_drop_bus_tx;
  localparam int DEPTH = 4;
`ifdef MDB_BROADCAST_EN
  localparam bit BC = 1'b1;
`else
  localparam bit BC = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       R = 1'b0;
  logic       tx_valid = 1'b0;
  logic [1:0] tx_dest = 2'b00;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, err;
  logic [7:0] Bus;
  logic [1:0] EN;
  logic [2:0] level;

  logic       v0 = 1'b0;
  logic [1:0] d0 = 2'b00;
  logic [7:0] x0 = 8'h00;
  logic       rdy0, busy0, err0;
  logic [7:0] bus0;
  logic [1:0] en0;
  logic [2:0] lvl0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [10:0] exp_q[$];
  logic [9:0]  exp0_q[$];
  int slot_cyc[$];
  int slot0_cyc[$];
  logic [7:0] rx_a = 8'h00, rx_b = 8'h00, rx_c = 8'h00;
  bit saw_full = 1'b0;

  multi_drop_bus_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(1)) dut (
    .CLK(CLK), .R(R), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_dest(tx_dest),
    .tx_data(tx_data), .Bus(Bus), .EN(EN), .busy(busy), .level(level), .err(err)
  );

  multi_drop_bus_tx #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(0)) dut0 (
    .CLK(CLK), .R(R), .tx_valid(v0), .tx_ready(rdy0), .tx_dest(d0),
    .tx_data(x0), .Bus(bus0), .EN(en0), .busy(busy0), .level(lvl0), .err(err0)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor for the gapped DUT: slot scoreboard plus occupancy/ready/err/busy model.
  int   ml  = 0;
  logic pp  = 1'b0;
  logic pe  = 1'b0;
  logic pen = 1'b0;
  always @(negedge CLK) begin
    logic [10:0] e;
    logic        popf;
    popf = 1'b0;
    if (!R) begin
      ml = 0; pp = 1'b0; pe = 1'b0; pen = 1'b0;
      chk("rst_bus", Bus, 8'h00);
      chk("rst_en", EN, 2'b00);
    end else begin
      if (EN != 2'b00) begin
        slot_cyc.push_back(cyc);
        if (pen) fail("gap_missing");
        if (exp_q.size() == 0) fail("unexpected_slot");
        else begin
          e = exp_q.pop_front();
          chk("slot", {EN, Bus}, e[9:0]);
          popf = e[10];
        end
      end
      ml = ml + (pp ? 1 : 0) - (popf ? 1 : 0);
    end
    if (ml == DEPTH) saw_full = 1'b1;
    chk("level", level, ml);
    chk("tx_ready", tx_ready, ml != DEPTH);
    chk("err", err, pe);
    chk("busy", busy, (ml != 0) || (EN != 2'b00) || pen);
    pen = R && (EN != 2'b00);
    pp  = R && tx_valid && (ml != DEPTH) && ((tx_dest != 2'b00) || BC);
    pe  = R && !BC && tx_valid && (ml != DEPTH) && (tx_dest == 2'b00);
    if (R) begin
      case (EN)
        2'b01:   rx_a = Bus;
        2'b10:   rx_b = Bus;
        2'b11:   rx_c = Bus;
        default: ;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (R && en0 != 2'b00) begin
      slot0_cyc.push_back(cyc);
      if (exp0_q.size() == 0) fail("unexpected_slot0");
      else chk("slot0", {en0, bus0}, exp0_q.pop_front());
    end
  end

  task automatic push(input bit sel, input logic [1:0] d, input logic [7:0] x);
    int n;
    n = 0;
    if (sel) begin v0 = 1'b1; d0 = d; x0 = x; end
    else begin tx_valid = 1'b1; tx_dest = d; tx_data = x; end
    @(negedge CLK);
    while (!(sel ? rdy0 : tx_ready) && n < 100) begin
      @(negedge CLK);
      n++;
    end
    if (!(sel ? rdy0 : tx_ready)) fail("push_timeout");
    else if (sel) exp0_q.push_back({d, x});
    else if (d != 2'b00) exp_q.push_back({1'b1, d, x});
    else if (BC) begin
      exp_q.push_back({1'b0, 2'b01, x});
      exp_q.push_back({1'b0, 2'b10, x});
      exp_q.push_back({1'b1, 2'b11, x});
    end
    @(posedge CLK);
    #1;
    v0 = 1'b0;
    tx_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit sel);
    int n;
    bit pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 300) begin
      pend = sel ? (exp0_q.size() != 0 || busy0) : (exp_q.size() != 0 || busy);
      if (pend) begin
        @(posedge CLK);
        #1;
        n++;
      end
    end
    chk(sel ? "drain0" : "drain", pend, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_level", level, 3'd0);
    chk("rst_busy", busy, 1'b0);
    #1 R = 1'b1;

    // Single command, latency and receiver
    @(posedge CLK); #1;
    push(1'b0, 2'b10, 8'hA5);
    chk("single_lat", EN, 2'b00);
    @(posedge CLK); #1;
    chk("single_slot", {EN, Bus}, {2'b10, 8'hA5});
    @(posedge CLK); #1;
    chk("single_after", {EN, Bus}, {2'b00, 8'hA5});
    wait_drain(1'b0);
    chk("rx_b", rx_b, 8'hA5);
    chk("rx_a_idle", rx_a, 8'h00);
    chk("rx_c_idle", rx_c, 8'h00);

    // Reset asserted mid-slot
    push(1'b0, 2'b01, 8'h5A);
    @(posedge CLK); #1;
    chk("midslot_en", {EN, Bus}, {2'b01, 8'h5A});
    #1 R = 1'b0;
    exp_q.delete();
    exp0_q.delete();
    #1;
    chk("async_en", EN, 2'b00);
    chk("async_bus", Bus, 8'h00);
    @(posedge CLK); #2 R = 1'b1;
    chk("rx_a_killed", rx_a, 8'h00);

    // Burst into the gapped DUT: fills the FIFO, slots every 2nd cycle
    @(posedge CLK); #1;
    slot_cyc.delete();
    saw_full = 1'b0;
    for (int i = 0; i < 8; i++) push(1'b0, 2'((i % 3) + 1), 8'h10 + 8'(i));
    wait_drain(1'b0);
    chk("burst_full", saw_full, 1'b1);
    chk("burst_slots", slot_cyc.size(), 8);
    for (int i = 1; i < slot_cyc.size(); i++) chk("burst_spacing", slot_cyc[i] - slot_cyc[i-1], 2);
    chk("burst_rx_b", rx_b, 8'h17);

    // Back-to-back slots with no gap
    slot0_cyc.delete();
    push(1'b1, 2'b01, 8'h11);
    push(1'b1, 2'b10, 8'h22);
    push(1'b1, 2'b11, 8'h33);
    wait_drain(1'b1);
    chk("b2b_slots", slot0_cyc.size(), 3);
    for (int i = 1; i < slot0_cyc.size(); i++) chk("b2b_spacing", slot0_cyc[i] - slot0_cyc[i-1], 1);

    // dest=00
    push(1'b0, 2'b00, 8'h3C);
`ifdef MDB_BROADCAST_EN
    chk("bc_err", err, 1'b0);
    wait_drain(1'b0);
    chk("bc_rx_a", rx_a, 8'h3C);
    chk("bc_rx_b", rx_b, 8'h3C);
    chk("bc_rx_c", rx_c, 8'h3C);
`else
    chk("rej_err", err, 1'b1);
    chk("rej_level", level, 3'd0);
    @(posedge CLK); #1;
    chk("rej_err_end", err, 1'b0);
    chk("rej_en", EN, 2'b00);
`endif

    // Stream with random idle cycles, pointers wrap several times
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge CLK); #1; end
      push(1'b0, 2'((i % 3) + 1), 8'h40 + 8'(i));
    end
    wait_drain(1'b0);

    // Reset mid-stream, then a normal transfer
    for (int i = 0; i < 4; i++) push(1'b0, 2'((i % 3) + 1), 8'h80 + 8'(i));
    #1 R = 1'b0;
    exp_q.delete();
    exp0_q.delete();
    #1;
    chk("stream_rst_level", level, 3'd0);
    chk("stream_rst_en", EN, 2'b00);
    @(posedge CLK); #2 R = 1'b1;
    @(posedge CLK); #1;
    push(1'b0, 2'b11, 8'hC3);
    wait_drain(1'b0);
    chk("post_rst_rx_c", rx_c, 8'hC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
